// File: rtl/tinyqv_debug_periph_pkg.sv
// Shared register indices, status bit positions and TX state encoding
// for the tinyQV debug peripheral block.
package tinyqv_debug_periph_pkg;

  localparam logic [3:0] REG_GPIO_SEL    = 4'd3;
  localparam logic [3:0] REG_UART_DATA   = 4'd6;
  localparam logic [3:0] REG_UART_STATUS = 4'd7;
  localparam logic [3:0] REG_UART_DIV    = 4'd8;
  localparam logic [3:0] REG_DEBUG       = 4'd12;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_IRQ_EN    = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic logic is_write(input logic [1:0] write_n);
    return write_n != 2'b11;
  endfunction

endpackage

// File: rtl/tinyqv_debug_periph_uart_tx_fifo.sv
// Debug UART transmitter: TX FIFO, runtime baud divider and 8N1 shifter.
// Optional TX-done interrupt is built when DEBUG_UART_TX_IRQ_EN is defined.
module debug_uart_tx_fifo
  import tinyqv_debug_periph_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 24,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          clr_ovf,
  input  logic          div_we,
  input  logic [15:0]   div_wdata,
`ifdef DEBUG_UART_TX_IRQ_EN
  input  logic          irq_en,
  output logic          uart_irq,
`endif
  output logic          txd,
  output logic          busy,
  output logic          full,
  output logic          overflow,
  output logic [CW-1:0] count,
  output logic [15:0]   div
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  tx_state_t     state;
  logic [15:0]   bit_div;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic          bit_end;

  assign empty   = count == '0;
  assign full    = count == CW'(FIFO_DEPTH);
  assign do_push = push && !full;
  assign bit_end = bit_cnt == bit_div;
  // Pop either from idle or in the last stop cycle so frames run back-to-back.
  assign do_pop  = !empty && ((state == TX_IDLE) || (state == TX_STOP && bit_end));
  assign busy    = !empty || (state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= 16'(DEFAULT_DIV);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
      if (push && full)  overflow <= 1'b1;
      else if (clr_ovf)  overflow <= 1'b0;
      if (div_we) div <= div_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      txd     <= 1'b1;
      bit_div <= 16'(DEFAULT_DIV);
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (do_pop) begin
            shreg   <= mem[rd_ptr];
            bit_div <= div;
            bit_cnt <= '0;
            txd     <= 1'b0;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            txd     <= shreg[0];
            state   <= TX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (do_pop) begin
              shreg   <= mem[rd_ptr];
              bit_div <= div;
              txd     <= 1'b0;
              state   <= TX_START;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef DEBUG_UART_TX_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) uart_irq <= 1'b0;
    else     uart_irq <= empty && (state == TX_IDLE) && irq_en;
  end
`endif

endmodule

// File: rtl/tinyqv_debug_periph.sv
// tinyQV debug peripherals: bus decode, GPIO select, debug flag, straps,
// 1 us time pulse and buffered debug UART. Optional macro: DEBUG_UART_TX_IRQ_EN.
module tinyqv_debug_periph
  import tinyqv_debug_periph_pkg::*;
#(
  parameter int CLOCK_MHZ   = 25,
  parameter int NUM_SEL     = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic [3:0]         reg_idx,
  input  logic [1:0]         write_n,
  input  logic [1:0]         read_n,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               data_ready,
  input  logic [NUM_SEL-1:0] sel_strap,
  output logic [NUM_SEL-1:0] gpio_out_sel,
  output logic               debug_reg_en,
  input  logic               dbg_strap,
  output logic               uart_txd,
  output logic               time_pulse
`ifdef DEBUG_UART_TX_IRQ_EN
  ,
  output logic               uart_irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (CLOCK_MHZ > 1) ? $clog2(CLOCK_MHZ) : 1;

  logic          bus_wr;
  logic          init_pending;
  logic [TW-1:0] time_cnt;
  logic          tx_busy;
  logic          tx_full;
  logic          tx_ovf;
  logic [CW-1:0] tx_count;
  logic [15:0]   tx_div;
  logic          irq_en_q;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign bus_wr      = sel && is_write(write_n);
  assign data_ready  = 1'b1;
  assign unused_bits = ^{read_n, data_in[31:16]};

  // Straps load once after reset; a bus write in that same cycle overrides them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out_sel <= '0;
      debug_reg_en <= 1'b0;
      init_pending <= 1'b1;
    end else begin
      if (init_pending) begin
        gpio_out_sel <= sel_strap;
        debug_reg_en <= dbg_strap;
        init_pending <= 1'b0;
      end
      if (bus_wr && reg_idx == REG_GPIO_SEL) gpio_out_sel <= data_in[NUM_SEL-1:0];
      if (bus_wr && reg_idx == REG_DEBUG)    debug_reg_en <= data_in[0];
    end
  end

`ifdef DEBUG_UART_TX_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_en_q <= 1'b0;
    else if (bus_wr && reg_idx == REG_UART_STATUS) irq_en_q <= data_in[ST_IRQ_EN];
  end
`else
  assign irq_en_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                time_cnt <= '0;
    else if (time_cnt == TW'(CLOCK_MHZ-1)) time_cnt <= '0;
    else                                    time_cnt <= time_cnt + 1'b1;
  end

  assign time_pulse = time_cnt == TW'(CLOCK_MHZ-1);

  debug_uart_tx_fifo #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .push      (bus_wr && reg_idx == REG_UART_DATA),
    .push_data (data_in[7:0]),
    .clr_ovf   (bus_wr && reg_idx == REG_UART_STATUS && data_in[ST_OVF]),
    .div_we    (bus_wr && reg_idx == REG_UART_DIV),
    .div_wdata (data_in[15:0]),
`ifdef DEBUG_UART_TX_IRQ_EN
    .irq_en    (irq_en_q),
    .uart_irq  (uart_irq),
`endif
    .txd       (uart_txd),
    .busy      (tx_busy),
    .full      (tx_full),
    .overflow  (tx_ovf),
    .count     (tx_count),
    .div       (tx_div)
  );

  always_comb begin
    status_word                            = '0;
    status_word[ST_BUSY]                   = tx_busy;
    status_word[ST_FULL]                   = tx_full;
    status_word[ST_OVF]                    = tx_ovf;
    status_word[ST_IRQ_EN]                 = irq_en_q;
    status_word[ST_COUNT_LSB+6:ST_COUNT_LSB] = 7'(tx_count);
  end

  always_comb begin
    data_out = 32'hFFFF_FFFF;
    if (sel) begin
      case (reg_idx)
        REG_GPIO_SEL:    data_out = 32'(gpio_out_sel);
        REG_UART_STATUS: data_out = status_word;
        REG_UART_DIV:    data_out = {16'h0000, tx_div};
        REG_DEBUG:       data_out = {31'h0, debug_reg_en};
        default:         data_out = 32'hFFFF_FFFF;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyqv_debug_periph.sv
// Directed self-checking bench for tinyqv_debug_periph (default parameters).
// Define DEBUG_UART_TX_IRQ_EN to also exercise the TX-done interrupt.
module tb_tinyqv_debug_periph;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [3:0]  reg_idx;
  logic [1:0]  write_n;
  logic [1:0]  read_n;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_ready;
  logic [1:0]  sel_strap;
  logic [1:0]  gpio_out_sel;
  logic        debug_reg_en;
  logic        dbg_strap;
  logic        uart_txd;
  logic        time_pulse;
`ifdef DEBUG_UART_TX_IRQ_EN
  logic        uart_irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tinyqv_debug_periph #(
    .CLOCK_MHZ   (25),
    .NUM_SEL     (2),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (24)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sel          (sel),
    .reg_idx      (reg_idx),
    .write_n      (write_n),
    .read_n       (read_n),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .sel_strap    (sel_strap),
    .gpio_out_sel (gpio_out_sel),
    .debug_reg_en (debug_reg_en),
    .dbg_strap    (dbg_strap),
    .uart_txd     (uart_txd),
    .time_pulse   (time_pulse)
`ifdef DEBUG_UART_TX_IRQ_EN
    ,
    .uart_irq     (uart_irq)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] idx, input logic [31:0] d);
    sel     = 1'b1;
    reg_idx = idx;
    write_n = 2'b10;
    data_in = d;
    tick();
    sel     = 1'b0;
    write_n = 2'b11;
    data_in = '0;
  endtask

  task automatic bus_read(input logic [3:0] idx, output logic [31:0] d);
    sel     = 1'b1;
    reg_idx = idx;
    read_n  = 2'b10;
    #1;
    d       = data_out;
    sel     = 1'b0;
    read_n  = 2'b11;
  endtask

  // Expected txd level k clocks into a frame of byte b with n clocks per bit.
  function automatic logic exp_bit(input logic [7:0] b, input int n, input int k);
    if (k < n)          return 1'b0;
    else if (k < 9 * n) return b[(k - n) / n];
    else                return 1'b1;
  endfunction

  task automatic test_reset();
    logic [31:0] rd;
    sel = 0; reg_idx = 0; write_n = 2'b11; read_n = 2'b11; data_in = 0;
    sel_strap = 2'b10; dbg_strap = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (gpio_out_sel !== 2'b00 || debug_reg_en !== 1'b0 || uart_txd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state: gpio=%b dbg=%b txd=%b expected gpio=00 dbg=0 txd=1",
               gpio_out_sel, debug_reg_en, uart_txd);
    end
    bus_read(4'd8, rd);
    checks++;
    if (rd !== 32'd24) begin
      errors++;
      $display("[TB] FAIL reset_div: got %h expected %h", rd, 32'd24);
    end
    bus_read(4'd7, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_status: got %h expected %h", rd, 32'h0);
    end
    tick();
    checks++;
    if (gpio_out_sel !== 2'b10 || debug_reg_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL strap_load: gpio=%b dbg=%b expected gpio=10 dbg=1",
               gpio_out_sel, debug_reg_en);
    end
  endtask

  task automatic test_strap_override();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bus_write(4'd3, 32'h1);
    checks++;
    if (gpio_out_sel !== 2'b01 || debug_reg_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL strap_override: gpio=%b dbg=%b expected gpio=01 dbg=1",
               gpio_out_sel, debug_reg_en);
    end
  endtask

  task automatic test_time_pulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      checks++;
      if (time_pulse !== ((c % 25) == 24)) begin
        errors++;
        $display("[TB] FAIL time_pulse cycle %0d: got %b expected %b",
                 c, time_pulse, ((c % 25) == 24));
      end
      tick();
    end
  endtask

  task automatic test_registers();
    logic [31:0] rd;
    bus_write(4'd3, 32'h7);
    bus_read(4'd3, rd);
    checks++;
    if (rd !== 32'h3 || gpio_out_sel !== 2'b11) begin
      errors++;
      $display("[TB] FAIL gpio_rw: got %h pin %b expected 00000003 pin 11", rd, gpio_out_sel);
    end
    bus_write(4'd12, 32'h0);
    bus_read(4'd12, rd);
    checks++;
    if (rd !== 32'h0 || debug_reg_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL debug_rw: got %h pin %b expected 00000000 pin 0", rd, debug_reg_en);
    end
    bus_write(4'd8, 32'h0001_2345);
    bus_read(4'd8, rd);
    checks++;
    if (rd !== 32'h0000_2345) begin
      errors++;
      $display("[TB] FAIL div_rw: got %h expected %h", rd, 32'h0000_2345);
    end
    bus_read(4'd5, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL unmapped_read: got %h expected ffffffff", rd);
    end
    bus_read(4'd6, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL uart_data_read: got %h expected ffffffff", rd);
    end
    sel = 1'b0; reg_idx = 4'd3;
    #1;
    checks++;
    if (data_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL unselected_read: got %h expected ffffffff", data_out);
    end
    tick();
  endtask

  task automatic test_uart_frame();
    logic [31:0] rd;
    logic [39:0] got;
    logic [39:0] exp;
    bus_write(4'd8, 32'd3);
    bus_write(4'd6, 32'h55);
    checks++;
    if (uart_txd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL txd_latency: got %b expected 1 one clock after write", uart_txd);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      got[k] = uart_txd;
      exp[k] = exp_bit(8'h55, 4, k);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL frame_55: got %h expected %h", got, exp);
    end
    tick();
    bus_read(4'd7, rd);
    checks++;
    if (rd !== 32'h0 || uart_txd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_after_frame: status %h txd %b expected 00000000 txd 1", rd, uart_txd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [39:0] got;
    logic [39:0] exp;
    logic [7:0]  b;
    bus_write(4'd6, 32'hA5);
    fork
      begin
        for (int i = 0; i < 9; i++)
          bus_write(4'd6, (i < 8) ? 32'(8'h10 + i) : 32'hEE);
        bus_read(4'd7, rd);
        checks++;
        if (rd !== 32'h0000_0807) begin
          errors++;
          $display("[TB] FAIL overflow_status: got %h expected %h", rd, 32'h0000_0807);
        end
        bus_write(4'd7, 32'h4);
        bus_read(4'd7, rd);
        checks++;
        if (rd !== 32'h0000_0803) begin
          errors++;
          $display("[TB] FAIL overflow_clear: got %h expected %h", rd, 32'h0000_0803);
        end
      end
      begin
        for (int f = 0; f < 9; f++) begin
          b = (f == 0) ? 8'hA5 : 8'(8'h10 + f - 1);
          for (int k = 0; k < 40; k++) begin
            tick();
            got[k] = uart_txd;
            exp[k] = exp_bit(b, 4, k);
          end
          checks++;
          if (got !== exp) begin
            errors++;
            $display("[TB] FAIL b2b_frame %0d: got %h expected %h", f, got, exp);
          end
        end
      end
    join
    tick();
    bus_read(4'd7, rd);
    checks++;
    if (rd !== 32'h0 || uart_txd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_drain: status %h txd %b expected 00000000 txd 1", rd, uart_txd);
    end
  endtask

  task automatic test_div_change();
    logic [31:0] rd;
    logic [79:0] got;
    logic [79:0] exp;
    bus_write(4'd6, 32'h0F);
    fork
      begin
        bus_write(4'd6, 32'hF0);
        repeat (8) tick();
        bus_write(4'd8, 32'd7);
        bus_read(4'd8, rd);
        checks++;
        if (rd !== 32'd7) begin
          errors++;
          $display("[TB] FAIL div_midframe_read: got %h expected %h", rd, 32'd7);
        end
      end
      begin
        got = '0; exp = '0;
        for (int k = 0; k < 40; k++) begin
          tick();
          got[k] = uart_txd;
          exp[k] = exp_bit(8'h0F, 4, k);
        end
        checks++;
        if (got !== exp) begin
          errors++;
          $display("[TB] FAIL div_old_frame: got %h expected %h", got, exp);
        end
        for (int k = 0; k < 80; k++) begin
          tick();
          got[k] = uart_txd;
          exp[k] = exp_bit(8'hF0, 8, k);
        end
        checks++;
        if (got !== exp) begin
          errors++;
          $display("[TB] FAIL div_new_frame: got %h expected %h", got, exp);
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    tick();
    bus_write(4'd8, 32'd3);
    bus_write(4'd6, 32'h00);
    bus_write(4'd6, 32'h81);
    bus_write(4'd6, 32'h81);
    bus_write(4'd6, 32'h81);
    repeat (4) tick();
    checks++;
    if (uart_txd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_data_level: got %b expected 0", uart_txd);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (uart_txd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset_txd: got %b expected 1", uart_txd);
    end
    bus_read(4'd7, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_fifo_flush: got %h expected 00000000", rd);
    end
    bus_read(4'd8, rd);
    checks++;
    if (rd !== 32'd24) begin
      errors++;
      $display("[TB] FAIL reset_div_restore: got %h expected %h", rd, 32'd24);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

`ifdef DEBUG_UART_TX_IRQ_EN
  task automatic test_irq();
    logic [31:0] rd;
    bus_write(4'd8, 32'd3);
    bus_write(4'd6, 32'h55);
    bus_write(4'd7, 32'h8);
    bus_read(4'd7, rd);
    checks++;
    if (rd !== 32'h9 || uart_irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_enable: status %h irq %b expected 00000009 irq 0", rd, uart_irq);
    end
    repeat (40) tick();
    checks++;
    if (uart_irq !== 1'b0 || uart_txd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_early: irq %b txd %b expected irq 0 txd 1", uart_irq, uart_txd);
    end
    tick();
    checks++;
    if (uart_irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_rise: got %b expected 1", uart_irq);
    end
  endtask
`else
  task automatic test_irq();
    logic [31:0] rd;
    bus_write(4'd7, 32'h8);
    bus_read(4'd7, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL irq_bit_absent: got %h expected 00000000", rd);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_strap_override();
    test_time_pulse();
    test_registers();
    test_uart_frame();
    test_back_to_back();
    test_div_change();
    test_reset_mid_frame();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
